acc_mem_arbiter: RTL
====================

// Module: acc_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one synchronous-read memory port between NREQ
//  accumulator engines (acc-array style FSMDs). Requesters present req+addr
//  and are granted one read per cycle. Read data returns to the winner one
//  cycle later, tagged by rvalid. Sits between the engines and the array RAM.
// PARAMETERS
//  NREQ      2   number of requesters (2..8)
//  AW        8   address width
//  DW        8   data width
//  MAX_BURST 16  max consecutive locked grants (used only with ACC_ARB_LOCK_EN)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req        in   NREQ      per-requester read request, held until gnt
//  req_addr   in   NREQ*AW   flattened addresses, slice i = [i*AW +: AW]
//  gnt        out  NREQ      one-hot grant, same cycle as mem_en
//  rvalid     out  NREQ      one-hot: rdata valid for requester i
//  rdata      out  DW        read data, shared by all requesters
//  mem_en     out  1         memory read enable
//  mem_addr   out  AW        memory address
//  mem_rdata  in   DW        memory data, valid 1 cycle after mem_en
//  req_lock   in   NREQ      burst lock (present only with ACC_ARB_LOCK_EN)
// BEHAVIOUR
//  - Clock is clk; reset is asynchronous, active-low (rst_n).
//  - Reset: rr_ptr=0, rvalid=0, rdata=0, burst_cnt=0. gnt, mem_en, mem_addr
//    are combinational, so they are 0 while rst_n=0.
//  - Grant (combinational): search req from index rr_ptr upward, wrapping
//    modulo NREQ. First set bit wins: gnt[w]=1, mem_en=1, mem_addr=addr[w].
//  - No req: gnt=0, mem_en=0, mem_addr=0, rr_ptr unchanged.
//  - On grant edge: rr_ptr <= (w+1)%NREQ; rsel <= w (registered).
//  - Response: the cycle after the grant, rvalid[rsel]=1 and rdata=mem_rdata
//    (passed through). Latency req-granted -> rvalid is exactly 1 cycle.
//  - rdata holds its last value when rvalid=0.
//  - Back-to-back grants are allowed every cycle; throughput is 1 read/clk.
//  - Requester protocol: req and addr are stable until gnt is seen. A
//    requester may reassert req in the cycle after gnt (its rvalid cycle).
//  - Dropping req before gnt is legal; nothing is issued for it.
//  - A single persistent requester is granted every cycle.
//  - All requesters active: each is granted once per NREQ cycles.
//  - Simultaneous events: rvalid for the previous grant and a new gnt in the
//    same cycle is normal operation and both are honoured.
//  - Reset mid-operation: an in-flight rvalid is discarded and rr_ptr returns
//    to 0. The memory read is harmless (reads only).
//  - Address width: mem_addr is exactly AW bits; no arithmetic on addresses.
//  - Internal state: rr_ptr [$clog2(NREQ)], rsel, rv_q, burst_cnt.
// CONFIGURATION
//  ACC_ARB_LOCK_EN defined:
//  - req_lock port exists.
//  - If the last winner w has req[w]&req_lock[w] and burst_cnt<MAX_BURST-1,
//    w wins again regardless of rr_ptr. rr_ptr is held and burst_cnt
//    increments.
//  - When the lock drops or MAX_BURST is reached: normal RR from w+1,
//    burst_cnt <= 0.
//  ACC_ARB_LOCK_EN undefined:
//  - No req_lock port, no burst_cnt.
//  - Pure round-robin as above; MAX_BURST is ignored.
// TESTING
//  1 Reset: rst_n=0 with req=2'b11 -> gnt=0, mem_en=0, rvalid=0. After
//    release, first grant goes to req0.
//  2 Single req1, addr=8'h05, mem returns 8'hA5 -> gnt=2'b10 at cycle t;
//    rvalid=2'b10, rdata=A5 at t+1.
//  3 req=2'b11 held 6 cycles -> gnt sequence 01,10,01,10,01,10; each rvalid
//    matches the prior gnt one cycle later.
//  4 Async reset pulse in the cycle after a grant to req1 -> no rvalid
//    appears. Next grant with req=11 goes to req0.
//  5 Engine model: two acc engines each sum 128 words (a[i]=i) through the
//    arbiter -> both report acc=8'hC0 (8192 mod 256 = 0? check:
//    sum 0..127=8128 -> 8'hC0). No lost or duplicated rvalid.
//  6 LOCK_EN, MAX_BURST=4: req0 locked, req1 waiting -> gnt 01,01,01,01,10,
//    then req0 again. Undefined: alternating 01,10.

Source files
------------

// File: rtl/acc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : acc_mem_arbiter
// Description : Round-robin arbiter sharing one synchronous-read memory port
//               between NREQ accumulator engines; optional burst lock
//               (ACC_ARB_LOCK_EN) lets a winner keep the port for MAX_BURST.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_mem_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
`ifdef ACC_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] r_rsel;
  logic               r_rv_q;
  logic [DW-1:0]      r_rdata_hold;

  logic [c_PTR_W-1:0] w_idx;
  logic [c_PTR_W-1:0] w_rr_win;
  logic               w_rr_found;
  logic               w_lock_hit;
  logic               w_found;
  logic [c_PTR_W-1:0] w_win;
  logic [c_PTR_W-1:0] w_next_ptr;

  // Scan requests starting at the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_idx      = '0;
    w_rr_win   = '0;
    w_rr_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = c_PTR_W'((int'(r_rr_ptr) + i) % NREQ);
      if (!w_rr_found && req[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_idx;
      end
    end
  end

`ifdef ACC_ARB_LOCK_EN
  localparam int c_BURST_W = $clog2(MAX_BURST + 1);

  logic [c_BURST_W-1:0] r_burst_cnt;

  // A locked winner from the previous cycle keeps the port until the cap.
  always_comb begin
    w_lock_hit = r_rv_q && req[r_rsel] && req_lock[r_rsel] &&
                 (r_burst_cnt < c_BURST_W'(MAX_BURST - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (w_found) begin
      r_burst_cnt <= w_lock_hit ? r_burst_cnt + c_BURST_W'(1) : '0;
    end
  end
`else
  always_comb begin
    w_lock_hit = 1'b0;
  end
`endif

  always_comb begin
    w_found    = rst_n && (w_lock_hit || w_rr_found);
    w_win      = w_lock_hit ? r_rsel : w_rr_win;
    w_next_ptr = (w_win == c_PTR_W'(NREQ - 1)) ? '0 : w_win + c_PTR_W'(1);
  end

  always_comb begin
    gnt      = '0;
    mem_addr = '0;
    mem_en   = w_found;
    if (w_found) begin
      gnt[w_win] = 1'b1;
      mem_addr   = req_addr[int'(w_win)*AW +: AW];
    end
  end

  // Read data passes straight through on the response cycle, else holds.
  always_comb begin
    rvalid = '0;
    if (r_rv_q) begin
      rvalid[r_rsel] = 1'b1;
    end
    rdata = r_rv_q ? mem_rdata : r_rdata_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_rsel       <= '0;
      r_rv_q       <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_rv_q <= w_found;
      if (w_found) begin
        r_rsel <= w_win;
        if (!w_lock_hit) begin
          r_rr_ptr <= w_next_ptr;
        end
      end
      if (r_rv_q) begin
        r_rdata_hold <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire
